// File: rtl/alu_pkg.sv
// Shared op-codes and FSM encodings for the sequential shifter.
// Optional feature macro: ALU_SHIFT_ROTATE_EN (op 11 = rotate-left).
package alu_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/alu_shift_stage.sv
// One 2^k shift stage of the sequential shifter.
// Op 11 rotates left with ALU_SHIFT_ROTATE_EN, else passes data through.
module alu_shift_stage
  import alu_pkg::*;
#(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  data_i,
  input  logic [SW-1:0] stage_i,
  input  logic [1:0]    op_i,
  input  logic          en_i,
  output logic [N-1:0]  data_o
);

  logic [SW:0]  shamt;
  logic [N-1:0] shifted;
`ifdef ALU_SHIFT_ROTATE_EN
  logic [SW:0]  rot_r;
`endif

  // Apply a 2^stage shift in the requested direction when enabled
  always_comb begin
    shamt   = (SW+1)'(1) << stage_i;
    shifted = data_i;
`ifdef ALU_SHIFT_ROTATE_EN
    rot_r   = (SW+1)'(N) - shamt;
`endif
    unique case (1'b1)
      op_i == OP_SLL: shifted = data_i << shamt;
      op_i == OP_SRL: shifted = data_i >> shamt;
      op_i == OP_SRA: shifted = $signed(data_i) >>> shamt;
      default: begin
`ifdef ALU_SHIFT_ROTATE_EN
        shifted = (data_i << shamt) | (data_i >> rot_r);
`else
        shifted = data_i;
`endif
      end
    endcase
    data_o = en_i ? shifted : data_i;
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Sequential log-stage barrel shifter: one 2^k stage per cycle.
// Optional feature macro: ALU_SHIFT_ROTATE_EN (op 11 = rotate-left).
module alu_shift_seq
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_a,
  input  logic [$clog2(N)-1:0] in_amt,
  input  logic [1:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_z,
  output logic                 busy
);

  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] K_TOP = SW'(SW-1);

  state_e        state_q, state_d;
  logic [SW-1:0] k_q, k_d;
  logic [SW-1:0] amt_q, amt_d;
  logic [1:0]    op_q, op_d;
  logic [N-1:0]  work_q, work_d;
  logic [N-1:0]  stage_out;
  logic          stage_en;

  alu_shift_stage #(
    .N  (N),
    .SW (SW)
  ) u_stage (
    .data_i  (work_q),
    .stage_i (k_q),
    .op_i    (op_q),
    .en_i    (stage_en),
    .data_o  (stage_out)
  );

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= K_TOP;
      amt_q   <= '0;
      op_q    <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
      work_q  <= work_d;
    end
  end

  // Next state: accept in IDLE, step stages in SHIFT, wait for consumer
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    amt_d   = amt_q;
    op_d    = op_q;
    work_d  = work_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_SHIFT;
          k_d     = K_TOP;
          amt_d   = in_amt;
          op_d    = in_op;
          work_d  = in_a;
        end
      end
      ST_SHIFT: begin
        work_d = stage_out;
        if (k_q == '0) begin
          state_d = ST_DONE;
          k_d     = K_TOP;
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs and stage enable decoded from state
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    stage_en  = (state_q == ST_SHIFT) && amt_q[k_q];
    out_z     = work_q;
  end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Randomized self-checking bench for alu_shift_seq.
// Model follows ALU_SHIFT_ROTATE_EN when defined.
module tb_alu_shift_seq;

  localparam int N  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a;
  logic [SW-1:0] in_amt;
  logic [1:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_z;
  logic          busy;

  int n_chk = 0;
  int n_err = 0;

  alu_shift_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a,
                                        input int amt,
                                        input int op);
    logic [63:0] dbl;
    case (op)
      0: return a << amt;
      1: return a >> amt;
      2: return $signed(a) >>> amt;
      default: begin
`ifdef ALU_SHIFT_ROTATE_EN
        dbl = {a, a} << amt;
        return dbl[63:32];
`else
        return a;
`endif
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] a,
                        input int amt,
                        input int op,
                        input logic [31:0] exp,
                        input int hold);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    chk("ready_wait", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_a      = a;
    in_amt    = SW'(amt);
    in_op     = 2'(op);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("busy_acc", 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_a     = $urandom;
      in_amt   = SW'($urandom);
      in_op    = 2'($urandom);
      in_valid = 1'($urandom);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(lat), 32'(SW));
    chk("result", out_z, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      in_a     = $urandom;
      tick();
      chk("hold_z", out_z, exp);
      chk("hold_vld", 32'(out_valid), 32'd1);
      chk("hold_rdy", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ret_vld", 32'(out_valid), 32'd0);
    chk("ret_rdy", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    int amt;
    int op;
    logic [31:0] rol_exp;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_amt    = '0;
    in_op     = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_z", out_z, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("rel_rdy", 32'(in_ready), 32'd1);

    run_op(32'h0000_0001, 31, 0, 32'h8000_0000, 0);
    run_op(32'h8000_0000, 31, 2, 32'hFFFF_FFFF, 0);
    run_op(32'h8000_0000, 31, 1, 32'h0000_0001, 0);
    run_op(32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 10);
`ifdef ALU_SHIFT_ROTATE_EN
    rol_exp = 32'h0000_0018;
`else
    rol_exp = 32'h8000_0001;
`endif
    run_op(32'h8000_0001, 4, 3, rol_exp, 2);

    for (int t = 0; t < 40; t++) begin
      a   = $urandom;
      amt = $urandom_range(0, 31);
      op  = $urandom_range(0, 3);
      run_op(a, amt, op, model(a, amt, op), $urandom_range(0, 3));
    end

    in_valid = 1'b1;
    in_a     = 32'h1234_5678;
    in_amt   = 5'd3;
    in_op    = 2'd0;
    tick();
    in_valid = 1'b0;
    tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_z", out_z, 32'h0);
    #3 rst_n = 1'b1;
    tick();
    chk("post_rst_rdy", 32'(in_ready), 32'd1);
    chk("post_rst_vld", 32'(out_valid), 32'd0);

    run_op(32'h0F0F_0000, 8, 1, 32'h000F_0F00, 1);

    $display("%0d/%0d checks passed", n_chk - n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_shift_seq.md
ALU_SHIFT_SEQ -- requirements
Module: alu_shift_seq

Interface
REQ-001 SHALL provide parameter N, default 32: operand/result width; legal values are powers of two, 32 or greater.
REQ-002 SHALL provide derived localparam SW = log2(N): shift-amount width and stage count.
REQ-003 SHALL provide port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL provide port in_valid, input, 1: operand request valid.
REQ-006 SHALL provide port in_ready, output, 1: block can accept a request.
REQ-007 SHALL provide port in_a, input, N: operand.
REQ-008 SHALL provide port in_amt, input, SW: shift amount.
REQ-009 SHALL provide port in_op, input, 2: shift operation code.
REQ-010 SHALL provide port out_valid, output, 1: result valid.
REQ-011 SHALL provide port out_ready, input, 1: consumer accepts the result.
REQ-012 SHALL provide port out_z, output, N: shift result.
REQ-013 SHALL provide port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-014 SHALL decode in_op as follows: 00 logical left (SLL); 01 logical right (SRL); 10 arithmetic right (SRA); 11 defined by REQ-030/REQ-031.
REQ-015 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-016 SHALL assert in_ready only in IDLE.
REQ-017 SHALL accept a request on a rising edge where in_valid and in_ready are both high, capturing in_a into the working register and latching in_amt and in_op, then entering SHIFT with stage index k = SW-1.
REQ-018 SHALL, in SHIFT, apply one stage per cycle: if amt[k] is 1, shift the working register by 2^k in the latched direction, otherwise hold it; then decrement k.
REQ-019 SHALL vacate bits with zero for SLL/SRL and with working-register bit N-1 for SRA.
REQ-020 SHALL enter DONE after the k = 0 stage, giving out_valid high exactly SW rising edges after the accepting edge (5 for N = 32), independent of amt.
REQ-021 SHALL keep out_z equal to the working register at all times and hold it stable while out_valid is high.
REQ-022 SHALL, in DONE, hold out_valid high until out_ready is high, then return to IDLE on that edge; in_ready rises in the following cycle (no back-to-back overlap).
REQ-023 SHALL ignore in_valid outside IDLE; input changes during SHIFT or DONE SHALL NOT affect the result.
REQ-024 SHALL produce out_z = in_a when amt = 0, after full latency.
REQ-025 SHALL give the result a width of exactly N with no carry-out; bits shifted beyond the MSB or LSB are discarded.

Reset
REQ-026 SHALL, while rst_n is low, immediately force state IDLE, k = SW-1, out_valid = 0, busy = 0, out_z = 0, and latched amt/op = 0, independent of clk.
REQ-027 SHALL, on reset asserted mid-operation, discard the operation with no partial result presented.
REQ-028 SHALL drive in_ready = 1 from the first rising edge after rst_n deasserts.

Configuration
REQ-029 SHALL use macro ALU_SHIFT_ROTATE_EN.
REQ-030 SHALL, with ALU_SHIFT_ROTATE_EN defined, treat op 11 as rotate-left (ROL): each active stage rotates by 2^k, with bits shifted out of the MSB re-entering at the LSB.
REQ-031 SHALL, without ALU_SHIFT_ROTATE_EN, treat op 11 as pass-through: out_z = in_a, with the same latency and handshake.

Structure
REQ-032 SHALL place the op-code localparams (OP_SLL, OP_SRL, OP_SRA, OP_ROL) and the FSM state encodings in the shared package alu_pkg.
REQ-033 SHALL instantiate one combinational sub-module, alu_shift_stage (inputs: data, stage index, op, enable; output: data), which performs a single 2^k shift; the FSM, counter and registers remain in alu_shift_seq.

Verification
REQ-034 SHALL cover: SLL in_a = 0x0000_0001, amt = 31 -> out_z = 0x8000_0000 with out_valid high 5 edges after accept.
REQ-035 SHALL cover: SRA in_a = 0x8000_0000, amt = 31 -> 0xFFFF_FFFF; SRL of the same -> 0x0000_0001.
REQ-036 SHALL cover: amt = 0, op SLL, in_a = 0xDEAD_BEEF -> 0xDEAD_BEEF after full latency.
REQ-037 SHALL cover: out_ready held low for 10 cycles after out_valid -> out_z stable and in_ready low throughout; in_valid pulses during this window are ignored.
REQ-038 SHALL cover: op 11, in_a = 0x8000_0001, amt = 4 -> 0x0000_0018 with ALU_SHIFT_ROTATE_EN, and 0x8000_0001 without it.
REQ-039 SHALL cover: rst_n pulsed low during SHIFT -> out_valid = 0 and busy = 0 immediately, and in_ready = 1 after release.
